// File: rtl/text_string_writer.sv
// text_string_writer
//   Upstream feeder for the bitmap/font placer. ASCII bytes are queued in a
//   small FIFO. Each byte is mapped to a 6-bit font index. Printable glyphs are
//   placed at a text cursor that advances by CHAR_PITCH and wraps by LINE_PITCH.
//   The placer has no busy output, so every issued glyph is followed by a fixed
//   wait. This gives CHAR_CYCLES+2 clocks from one add_fnt pulse to the next.
//
//   Handshake: a byte is taken on a rising edge where chr_vld & chr_rdy.
//   chr_rdy is registered (= FIFO not full). A pop on a full FIFO therefore
//   does not let a push in during the same cycle.
//
//   Configuration macro: TSW_LOWERCASE_EN. When defined, 'a'..'z' map to the
//   same indices as 'A'..'Z'. Otherwise lowercase bytes are discarded.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   set_cur   in   1-clk pulse: load origin and cursor from cur_x/cur_y
//   cur_x     in   [9:0] new origin/cursor x
//   cur_y     in   [8:0] new origin/cursor y
//   chr_vld   in   ASCII byte valid
//   chr       in   [7:0] ASCII byte
//   chr_rdy   out  FIFO not full
//   add_fnt   out  1-clk draw pulse to the placer
//   fnt_indx  out  [5:0] glyph index
//   xloc      out  [9:0] glyph top-left x
//   yloc      out  [8:0] glyph top-left y
//   busy      out  FIFO non-empty or FSM not idle
module text_string_writer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CHAR_CYCLES = 256,
  parameter int CHAR_PITCH  = 14,
  parameter int LINE_PITCH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_cur,
  input  logic [9:0] cur_x,
  input  logic [8:0] cur_y,
  input  logic       chr_vld,
  input  logic [7:0] chr,
  output logic       chr_rdy,
  output logic       add_fnt,
  output logic [5:0] fnt_indx,
  output logic [9:0] xloc,
  output logic [8:0] yloc,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CHAR_CYCLES);
  // WAIT lasts CHAR_CYCLES-1 clocks. IDLE and DECODE add 2 more clocks, and
  // ISSUE adds 1, giving the CHAR_CYCLES+2 pulse-to-pulse spacing.
  localparam logic [CW-1:0] WAIT_LOAD = CW'(CHAR_CYCLES - 2);
  localparam logic [10:0]   X_MAX     = 11'(640 - 13);
  localparam logic [10:0]   Y_MAX     = 11'(480 - 16);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ISSUE  = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push, pop;

  assign push = chr_vld & chr_rdy;
  assign pop  = (state == S_IDLE) && (count != '0);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Storage holds no reset; a reset only clears the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= chr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      chr_rdy <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_nxt;
      chr_rdy <= (count_nxt != FULL_CNT);
    end
  end

  // ------------------------------------------------------- byte decoding
  logic [7:0] chr_q;
  logic       glyph_ok;
  logic [5:0] glyph_idx;
  logic       is_lf;

  assign is_lf = (chr_q == 8'h0A);

  always_comb begin
    glyph_ok  = 1'b0;
    glyph_idx = '0;
    if (chr_q >= 8'h30 && chr_q <= 8'h39) begin
      glyph_ok  = 1'b1;
      glyph_idx = 6'(chr_q - 8'h30);
    end else if (chr_q >= 8'h41 && chr_q <= 8'h5A) begin
      glyph_ok  = 1'b1;
      glyph_idx = 6'(chr_q - 8'h41 + 8'd10);
`ifdef TSW_LOWERCASE_EN
    end else if (chr_q >= 8'h61 && chr_q <= 8'h7A) begin
      glyph_ok  = 1'b1;
      glyph_idx = 6'(chr_q - 8'h61 + 8'd10);
`endif
    end else begin
      case (chr_q)
        8'h20: begin glyph_ok = 1'b1; glyph_idx = 6'd36; end
        8'h3D: begin glyph_ok = 1'b1; glyph_idx = 6'd37; end
        8'h3E: begin glyph_ok = 1'b1; glyph_idx = 6'd38; end
        8'h2C: begin glyph_ok = 1'b1; glyph_idx = 6'd39; end
        8'h28: begin glyph_ok = 1'b1; glyph_idx = 6'd40; end
        8'h29: begin glyph_ok = 1'b1; glyph_idx = 6'd41; end
        default: begin glyph_ok = 1'b0; glyph_idx = '0; end
      endcase
    end
  end

  // ------------------------------------------------------ cursor / wrap
  logic [9:0] org_x, cur_xr;
  logic [8:0] org_y, cur_yr;
  logic [10:0] adv_y;
  logic [8:0]  next_line_y;
  logic        x_wrap;
  logic [9:0]  place_x;
  logic [8:0]  place_y;

  // Wrap comparisons are made on 11-bit values so a cursor pushed past the
  // right or bottom edge is seen before it is truncated.
  assign adv_y       = {2'b00, cur_yr} + 11'(LINE_PITCH);
  assign next_line_y = (adv_y > Y_MAX) ? org_y : adv_y[8:0];
  assign x_wrap      = ({1'b0, cur_xr} > X_MAX);
  assign place_x     = x_wrap ? org_x : cur_xr;
  assign place_y     = x_wrap ? next_line_y : cur_yr;

  // ----------------------------------------------------------------- FSM
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      chr_q    <= '0;
      wait_cnt <= '0;
      fnt_indx <= '0;
      xloc     <= '0;
      yloc     <= '0;
      org_x    <= '0;
      org_y    <= '0;
      cur_xr   <= '0;
      cur_yr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            chr_q <= mem[rd_ptr];
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (glyph_ok) begin
            fnt_indx <= glyph_idx;
            xloc     <= place_x;
            yloc     <= place_y;
            state    <= S_ISSUE;
          end else begin
            if (is_lf) begin
              cur_xr <= org_x;
              cur_yr <= next_line_y;
            end
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cur_xr   <= xloc + 10'(CHAR_PITCH);
          cur_yr   <= yloc;
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_IDLE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      // A new cursor overrides any advance made in the same cycle. The latched
      // glyph position and the queued bytes are left alone.
      if (set_cur) begin
        org_x  <= cur_x;
        org_y  <= cur_y;
        cur_xr <= cur_x;
        cur_yr <= cur_y;
      end
    end
  end

  assign add_fnt = (state == S_ISSUE);
  assign busy    = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_text_string_writer.sv
module tb_text_string_writer;

  localparam int C = 256;

  // ------------------------------------------------ clock / reset block
  logic       clk = 1'b0;
  logic       rst;
  logic       set_cur;
  logic [9:0] cur_x;
  logic [8:0] cur_y;
  logic       chr_vld;
  logic [7:0] chr;
  logic       chr_rdy, add_fnt, busy;
  logic [5:0] fnt_indx;
  logic [9:0] xloc;
  logic [8:0] yloc;

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  text_string_writer dut (
    .clk(clk), .rst(rst), .set_cur(set_cur), .cur_x(cur_x), .cur_y(cur_y),
    .chr_vld(chr_vld), .chr(chr), .chr_rdy(chr_rdy), .add_fnt(add_fnt),
    .fnt_indx(fnt_indx), .xloc(xloc), .yloc(yloc), .busy(busy)
  );

  // ---------------------------------------------------------- checking
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ------------------------------------------------- monitor / scoreboard
  // Entries are {fnt_indx, xloc, yloc}.
  logic [24:0] exp_q[$];
  logic [24:0] got_q[$];
  longint      pulse_t[$];

  always @(negedge clk) begin
    if (rst === 1'b0 && add_fnt === 1'b1) begin
      got_q.push_back({fnt_indx, xloc, yloc});
      pulse_t.push_back(cyc);
    end
  end

  // ------------------------------------------------------ reference model
  // Text-terminal view: a cursor and an origin. Bytes are applied in the
  // order they were accepted.
  int ox, oy, mx, my;

  function automatic int ref_index(input logic [7:0] b);
    string punct;
    punct = " =>,()";
    if (b >= "0" && b <= "9") return int'(b) - int'("0");
    if (b >= "A" && b <= "Z") return 10 + int'(b) - int'("A");
`ifdef TSW_LOWERCASE_EN
    if (b >= "a" && b <= "z") return 10 + int'(b) - int'("a");
`endif
    for (int k = 0; k < punct.len(); k++)
      if (punct[k] == b) return 36 + k;
    if (b == 8'h0A) return -2;
    return -1;
  endfunction

  task automatic model_feed(input logic [7:0] b);
    int idx, px, py;
    idx = ref_index(b);
    if (idx == -2) begin
      mx = ox;
      my = my + 16;
      if (my > 464) my = oy;
    end else if (idx >= 0) begin
      px = mx;
      py = my;
      if (mx > 627) begin
        px = ox;
        py = my + 16;
        if (py > 464) py = oy;
      end
      exp_q.push_back({6'(idx), 10'(px), 9'(py)});
      mx = px + 14;
      my = py;
    end
  endtask

  task automatic model_reset();
    ox = 0; oy = 0; mx = 0; my = 0;
    exp_q.delete();
  endtask

  // ------------------------------------------------------- driver tasks
  // All drivers start and end on a falling edge.
  task automatic do_set_cur(input int x, input int y);
    set_cur = 1'b1;
    cur_x = 10'(x);
    cur_y = 9'(y);
    @(negedge clk);
    set_cur = 1'b0;
    ox = x; oy = y; mx = x; my = y;
  endtask

  task automatic push_wait(input logic [7:0] b);
    int n;
    n = 0;
    chr_vld = 1'b1;
    chr = b;
    while (chr_rdy !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check_eq("push_timeout", 32'(n), 0);
    else model_feed(b);
    @(negedge clk);
    chr_vld = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) push_wait(s[i]);
  endtask

  task automatic wait_pulses(input int k);
    int n;
    n = 0;
    while (got_q.size() < k && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("pulse_wait", 32'(got_q.size() >= k), 1);
  endtask

  // Waits for busy to drop, returns that cycle, then compares all glyphs.
  task automatic drain(input string tag, output longint fall_t);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_drain"}, 32'(busy), 0);
    fall_t = cyc;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_glyph"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_add_fnt",  32'(add_fnt), 0);
    check_eq("rst_chr_rdy",  32'(chr_rdy), 1);
    check_eq("rst_busy",     32'(busy), 0);
    check_eq("rst_fnt_indx", 32'(fnt_indx), 0);
    check_eq("rst_xloc",     32'(xloc), 0);
    check_eq("rst_yloc",     32'(yloc), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    pulse_t.delete();
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    longint fall_t;
    int     acc, bad;
    string  pool, s;
    logic [7:0] b;

    rst = 1'b1; set_cur = 1'b0; cur_x = '0; cur_y = '0; chr_vld = 1'b0; chr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    apply_reset();

    // 1: basic placement and pulse spacing
    do_set_cur(100, 50);
    pulse_t.delete();
    push_str("A1");
    drain("t1", fall_t);
    check_eq("t1_spacing", 32'(pulse_t[1] - pulse_t[0]), C + 2);
    check_eq("t1_busy_fall", 32'(fall_t - pulse_t[1]), C);

    // 2: right-edge wrap
    do_set_cur(620, 0);
    push_str("BC");
    drain("t2", fall_t);

    // 3: line feeds down to the bottom, then y wraps to the origin row
    do_set_cur(0, 0);
    for (int i = 0; i < 30; i++) push_wait(8'h0A);
    push_str("X");
    drain("t3", fall_t);

    // 4: overfill the FIFO while a glyph is waiting
    do_set_cur(10, 10);
    pulse_t.delete();
    push_str("0");
    wait_pulses(1);
    s = "0123456789ABCDEFG";
    acc = 0;
    chr_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chr = s[i];
      if (chr_rdy === 1'b1) begin
        model_feed(s[i]);
        acc++;
      end
      @(negedge clk);
    end
    chr_vld = 1'b0;
    check_eq("t4_accepted", 32'(acc), 16);
    check_eq("t4_rdy_low", 32'(chr_rdy), 0);
    check_eq("t4_busy", 32'(busy), 1);
    drain("t4", fall_t);
    bad = 0;
    for (int i = 1; i < pulse_t.size(); i++)
      if (pulse_t[i] - pulse_t[i-1] != C + 2) bad++;
    check_eq("t4_pulses", 32'(pulse_t.size()), 17);
    check_eq("t4_spacing_bad", 32'(bad), 0);
    check_eq("t4_busy_fall", 32'(fall_t - pulse_t[pulse_t.size()-1]), C);

    // 5: lowercase / unmapped handling
    do_set_cur(200, 100);
    push_str("a#=");
    drain("t5", fall_t);

    // 6: reset during WAIT with bytes queued
    do_set_cur(300, 200);
    push_str("0");
    wait_pulses(1);
    push_str("123");
    repeat (20) @(negedge clk);
    apply_reset();
    repeat (800) @(negedge clk);
    check_eq("t6_no_pulse", 32'(got_q.size()), 0);
    check_eq("t6_idle", 32'(busy), 0);
    // reset landing on the ISSUE cycle itself
    push_str("5");
    wait_pulses(1);
    rst = 1'b1;
    #1;
    check_eq("t6_issue_drop", 32'(add_fnt), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    repeat (600) @(negedge clk);
    check_eq("t6_no_pulse2", 32'(got_q.size()), 0);

    // random text against the model
    pool = "0123456789ABCDEFXYZ =>,()#az~";
    for (int r = 0; r < 6; r++) begin
      do_set_cur($urandom_range(0, 639), $urandom_range(0, 479));
      for (int i = 0; i < 14; i++) begin
        if ($urandom_range(0, 7) == 0) b = 8'h0A;
        else b = pool[$urandom_range(0, pool.len() - 1)];
        push_wait(b);
      end
      drain("rand", fall_t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
